// File: rtl/debounce_scheduler.sv
// Debounces NUM_BUTTONS raw inputs with one shared settle timer, served round-robin.
// Qualified edges are queued as press/release events in a small first-word-fall-through FIFO.
module debounce_scheduler #(
  parameter int NUM_BUTTONS   = 5,
  parameter int SETTLE_CYCLES = 1000000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                           clock_100mhz,
  input  logic                           reset_n,
  input  logic [NUM_BUTTONS-1:0]         raw,
  output logic [NUM_BUTTONS-1:0]         debounced,
  output logic                           event_valid,
  input  logic                           event_ready,
  output logic [$clog2(NUM_BUTTONS)-1:0] event_button,
  output logic                           event_pressed,
  output logic                           overflow,
  output logic                           busy,
  output logic [1:0]                     o_fsm_state
);

  localparam int IW = $clog2(NUM_BUTTONS);
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [NUM_BUTTONS-1:0] r_sync1;
  logic [NUM_BUTTONS-1:0] r_rs;
  logic [NUM_BUTTONS-1:0] r_debounced;
  logic [NUM_BUTTONS-1:0] w_m;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          r_last_idx;
  logic [IW-1:0]          w_pick;
  logic [IW-1:0]          w_cand;
  logic                   w_found;
  logic [CW-1:0]          r_cnt;
  logic                   w_cnt_clr;
  logic                   w_cnt_inc;
  logic                   w_load_idx;
  logic                   w_commit;

  // FIFO storage: each entry is {button index, pressed}.
  logic [IW:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_overflow;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push_ok;

  assign w_m = r_rs ^ r_debounced;

  // First set bit of the mismatch vector, searching upward from the entry after r_last_idx.
  always_comb begin
    w_pick  = r_last_idx;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_BUTTONS; i++) begin
      w_cand = IW'((int'(r_last_idx) + i) % NUM_BUTTONS);
      if (!w_found && w_m[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_load_idx = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_m != '0) begin
          w_load_idx = 1'b1;
          w_cnt_clr  = 1'b1;
          w_next     = TIMING;
        end
      end
      TIMING: begin
        if (!w_m[r_idx]) begin
          w_cnt_clr = 1'b1;
          w_next    = IDLE;
        end else if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
          w_next = COMMIT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      COMMIT: begin
        w_commit = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_sync1     <= '0;
      r_rs        <= '0;
      r_debounced <= '0;
      r_idx       <= '0;
      r_last_idx  <= IW'(NUM_BUTTONS - 1);
      r_cnt       <= '0;
    end else begin
      r_state <= w_next;
      r_sync1 <= raw;
      r_rs    <= r_sync1;
      if (w_load_idx) r_idx <= w_pick;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_commit) begin
        r_debounced[r_idx] <= r_rs[r_idx];
        r_last_idx         <= r_idx;
      end
    end
  end

  // Handshake: an event transfers on any edge where event_valid && event_ready;
  // the head entry stays stable while event_valid is high and event_ready is low.
  assign w_full    = (r_count == (AW + 1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && event_ready;
  assign w_push_ok = w_commit && (!w_full || w_pop);

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_commit && w_full && !w_pop;
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= {r_idx, r_rs[r_idx]};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + (AW + 1)'(1);
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - (AW + 1)'(1);
      end
    end
  end

  assign debounced     = r_debounced;
  assign event_valid   = !w_empty;
  assign event_button  = r_mem[r_rd_ptr][IW:1];
  assign event_pressed = r_mem[r_rd_ptr][0];
  assign overflow      = r_overflow;
  assign busy          = (r_state != IDLE);
  assign o_fsm_state   = r_state;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler (4 buttons, 8 settle cycles, 2-entry FIFO).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_debounce_scheduler;

  logic       clk;
  logic       reset_n;
  logic [3:0] raw;
  logic [3:0] debounced;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_button;
  logic       event_pressed;
  logic       overflow;
  logic       busy;
  logic [1:0] fsm_state;

  int errors = 0;
  int checks = 0;

  debounce_scheduler #(
    .NUM_BUTTONS  (4),
    .SETTLE_CYCLES(8),
    .FIFO_DEPTH   (2)
  ) dut (
    .clock_100mhz (clk),
    .reset_n      (reset_n),
    .raw          (raw),
    .debounced    (debounced),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .event_button (event_button),
    .event_pressed(event_pressed),
    .overflow     (overflow),
    .busy         (busy),
    .o_fsm_state  (fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_event(input string tag, input logic [1:0] btn, input logic pr);
    chk({tag, "_valid"}, 32'(event_valid), 32'd1);
    chk({tag, "_button"}, 32'(event_button), 32'(btn));
    chk({tag, "_pressed"}, 32'(event_pressed), 32'(pr));
  endtask

  initial begin
    reset_n     = 1'b0;
    raw         = 4'b0000;
    event_ready = 1'b0;

    // 1. reset state
    step(3);
    chk("rst_debounced", 32'(debounced), 32'd0);
    chk("rst_valid", 32'(event_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    reset_n = 1'b1;
    step(2);

    // 2. single press on button 2, consumer ready
    event_ready = 1'b1;
    raw = 4'b0100;
    step(2);
    chk("t2_busy_e1", 32'(busy), 32'd0);
    step(1);
    chk("t2_busy_e2", 32'(busy), 32'd1);
    step(8);
    chk("t2_state_e10", 32'(fsm_state), 32'd2);
    chk("t2_deb_e10", 32'(debounced), 32'h0);
    chk("t2_valid_e10", 32'(event_valid), 32'd0);
    step(1);
    chk("t2_deb_e11", 32'(debounced), 32'h4);
    chk_event("t2_ev", 2'd2, 1'b1);
    chk("t2_busy_e11", 32'(busy), 32'd0);
    step(1);
    chk("t2_popped", 32'(event_valid), 32'd0);

    // 3. glitch on button 1 for 5 cycles is rejected
    raw = 4'b0110;
    step(5);
    chk("t3_busy_timing", 32'(busy), 32'd1);
    raw = 4'b0100;
    step(3);
    chk("t3_busy_back", 32'(busy), 32'd0);
    step(12);
    chk("t3_deb", 32'(debounced), 32'h4);
    chk("t3_valid", 32'(event_valid), 32'd0);
    chk("t3_overflow", 32'(overflow), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);

    // 4. buttons 0 and 3 together, from a fresh reset so button 0 wins first
    raw = 4'b0000;
    reset_n = 1'b0;
    step(2);
    chk("t4_rst_deb", 32'(debounced), 32'h0);
    reset_n = 1'b1;
    step(2);
    raw = 4'b1001;
    step(11);
    chk("t4_valid_e10", 32'(event_valid), 32'd0);
    step(1);
    chk_event("t4_ev0_press", 2'd0, 1'b1);
    chk("t4_deb_e11", 32'(debounced), 32'h1);
    step(1);
    chk("t4_pop0", 32'(event_valid), 32'd0);
    step(8);
    chk("t4_valid_e20", 32'(event_valid), 32'd0);
    step(1);
    chk_event("t4_ev3_press", 2'd3, 1'b1);
    chk("t4_deb_e21", 32'(debounced), 32'h9);
    step(1);
    chk("t4_pop3", 32'(event_valid), 32'd0);
    raw = 4'b0000;
    step(12);
    chk_event("t4_ev0_release", 2'd0, 1'b0);
    chk("t4_deb_rel0", 32'(debounced), 32'h8);
    step(10);
    chk_event("t4_ev3_release", 2'd3, 1'b0);
    chk("t4_deb_rel3", 32'(debounced), 32'h0);
    step(1);

    // 5. consumer stalled: third event overflows the 2-entry FIFO
    event_ready = 1'b0;
    raw = 4'b0111;
    step(12);
    chk_event("t5_head_a", 2'd0, 1'b1);
    step(10);
    chk_event("t5_head_hold", 2'd0, 1'b1);
    chk("t5_deb_e21", 32'(debounced), 32'h3);
    chk("t5_ovf_e21", 32'(overflow), 32'd0);
    step(9);
    chk("t5_ovf_e30", 32'(overflow), 32'd0);
    step(1);
    chk("t5_ovf_e31", 32'(overflow), 32'd1);
    chk("t5_deb_e31", 32'(debounced), 32'h7);
    chk_event("t5_head_after_ovf", 2'd0, 1'b1);
    step(1);
    chk("t5_ovf_e32", 32'(overflow), 32'd0);
    event_ready = 1'b1;
    step(1);
    chk_event("t5_head_b", 2'd1, 1'b1);
    step(1);
    chk("t5_drained", 32'(event_valid), 32'd0);
    event_ready = 1'b0;

    // 6. asynchronous reset while timing (counter at 4)
    raw = 4'b1111;
    step(7);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    chk("t6_state_pre", 32'(fsm_state), 32'd1);
    reset_n = 1'b0;
    raw = 4'b0000;
    #1;
    chk("t6_async_deb", 32'(debounced), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_valid", 32'(event_valid), 32'd0);
    chk("t6_async_ovf", 32'(overflow), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(20);
    chk("t6_post_valid", 32'(event_valid), 32'd0);
    chk("t6_post_busy", 32'(busy), 32'd0);
    chk("t6_post_deb", 32'(debounced), 32'h0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
